clk_mult_ctrl: RTL and testbench

CLK_MULT_CTRL -- requirements
Module: clk_mult_ctrl

---
 rtl/clk_ctrl_pkg.sv | 25 ++
 rtl/lock_sync.sv | 24 ++
 rtl/clk_mult_ctrl.sv | 164 ++++++++++++++++
 tb/tb_clk_mult_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock-multiplier switch controller.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RELOCK,
        SETTLE,
        RESUME
    } state_t;

    localparam logic MODE_BASE = 1'b0;
    localparam logic MODE_MULT = 1'b1;

    localparam int DEF_DRAIN_CYCLES   = 4;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock; 2-cycle latency, resets low.
module lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    assign o_sync = r_s2;

endmodule

// File: rtl/clk_mult_ctrl.sv
// Gates the core clock, switches the multiplier mode and waits for a settled lock before ungating.
// Relock watchdog and sticky err exist only when CLK_MULT_CTRL_TIMEOUT_EN is defined.
module clk_mult_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic base_clock,
    input  logic reset,
    input  logic req_valid,
    input  logic req_mult,
    output logic req_ready,
    input  logic lock,
    output logic multiply,
    output logic clk_en,
    output logic done,
    output logic err
);

    localparam int CW = $clog2(max3(DRAIN_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)) + 1;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_mult, w_mult_nxt;
    logic          r_target, w_target_nxt;
    logic          r_clk_en, w_clk_en_nxt;
    logic          r_done, w_done_nxt;
    logic          w_lock_s;

    lock_sync u_lock_sync (
        .i_clk   (base_clock),
        .i_rst   (reset),
        .i_async (lock),
        .o_sync  (w_lock_s)
    );

`ifdef CLK_MULT_CTRL_TIMEOUT_EN
    logic [CW-1:0] r_wdog, w_wdog_nxt;
    logic          r_err, w_err_nxt;
`endif

    always_ff @(posedge base_clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mult   <= MODE_BASE;
            r_target <= MODE_BASE;
            r_clk_en <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mult   <= w_mult_nxt;
            r_target <= w_target_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_done   <= w_done_nxt;
        end
    end

`ifdef CLK_MULT_CTRL_TIMEOUT_EN
    always_ff @(posedge base_clock) begin
        if (reset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_nxt;
            r_err  <= w_err_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mult_nxt   = r_mult;
        w_target_nxt = r_target;
        w_clk_en_nxt = r_clk_en;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_mult == r_mult) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_target_nxt = req_mult;
                        w_clk_en_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
                    w_mult_nxt  = r_target;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELOCK;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RELOCK: begin
                if (w_lock_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // Any lock drop restarts the settle window from zero.
                if (!w_lock_s) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELOCK;
                end else if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RESUME;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RESUME: begin
                w_clk_en_nxt = 1'b1;
                w_done_nxt   = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

`ifdef CLK_MULT_CTRL_TIMEOUT_EN
        w_err_nxt  = r_err;
        w_wdog_nxt = r_wdog;
        if (r_state == IDLE && req_valid) begin
            w_err_nxt = 1'b0;
        end
        if (r_state == DRAIN) begin
            w_wdog_nxt = '0;
        end else if (r_state == RELOCK || r_state == SETTLE) begin
            // A switch only starts when target differs, so ~target is the old mode.
            if (r_wdog == CW'(TIMEOUT_CYCLES - 1)) begin
                w_mult_nxt  = ~r_target;
                w_err_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = RESUME;
            end else begin
                w_wdog_nxt = r_wdog + CW'(1);
            end
        end
`endif
    end

    assign req_ready = (r_state == IDLE);
    assign multiply  = r_mult;
    assign clk_en    = r_clk_en;
    assign done      = r_done;
`ifdef CLK_MULT_CTRL_TIMEOUT_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_mult_ctrl.sv
// Directed bench for clk_mult_ctrl: mode switches, lock glitches, timeout, reset abort.
module tb_clk_mult_ctrl;

    logic clk = 1'b0;
    logic reset, req_valid, req_mult, lock;
    logic req_ready, multiply, clk_en, done, err;

    int n_checks = 0;
    int n_errs   = 0;

    clk_mult_ctrl #(
        .DRAIN_CYCLES   (4),
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .base_clock (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_mult   (req_mult),
        .req_ready  (req_ready),
        .lock       (lock),
        .multiply   (multiply),
        .clk_en     (clk_en),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Cycle 0 issues the request; req_valid stays high for cycles 1..hold with the
    // opposite mode; the lock pin is low for cycles [lock_lo, lock_hi).
    task automatic run_req(input logic mult, input int hold, input int lock_lo,
                           input int lock_hi, input int ncyc,
                           output int low_cnt, output int done_cnt, output int done_at,
                           output int rdy_hold, output logic rdy0);
        low_cnt  = 0;
        done_cnt = 0;
        done_at  = -1;
        rdy_hold = 0;
        rdy0     = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            req_valid = (k <= hold);
            req_mult  = (k == 0) ? mult : ~mult;
            lock      = !(k >= lock_lo && k < lock_hi);
            @(negedge clk);
            if (k == 0) rdy0 = req_ready;
            else if (k <= hold && req_ready) rdy_hold++;
            if (!clk_en) low_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lock      = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_mult = 1'b0; lock = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (multiply !== 1'b0) begin n_errs++; $display("FAIL reset_multiply: got %b want 0", multiply); end
        n_checks++; if (clk_en !== 1'b1) begin n_errs++; $display("FAIL reset_clk_en: got %b want 1", clk_en); end
        n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (req_ready !== 1'b1) begin n_errs++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    // Lock already settled: 4 DRAIN + 1 RELOCK + 16 SETTLE + 1 RESUME cycles gated.
    task automatic test_switch_up;
        int lo, dn, at, rh; logic r0;
        run_req(1'b1, 0, 0, 0, 30, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (r0 !== 1'b1) begin n_errs++; $display("FAIL up_ready: got %b want 1", r0); end
        n_checks++; if (lo != 22) begin n_errs++; $display("FAIL up_gated: got %0d want 22", lo); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL up_done_cnt: got %0d want 1", dn); end
        n_checks++; if (at != 23) begin n_errs++; $display("FAIL up_done_at: got %0d want 23", at); end
        n_checks++; if (multiply !== 1'b1) begin n_errs++; $display("FAIL up_multiply: got %b want 1", multiply); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL up_err: got %b want 0", err); end
    endtask

    task automatic test_same_mode;
        int lo, dn, at, rh; logic r0;
        run_req(1'b1, 0, 0, 0, 5, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (lo != 0) begin n_errs++; $display("FAIL same_gated: got %0d want 0", lo); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL same_done_cnt: got %0d want 1", dn); end
        n_checks++; if (at != 1) begin n_errs++; $display("FAIL same_done_at: got %0d want 1", at); end
        n_checks++; if (multiply !== 1'b1) begin n_errs++; $display("FAIL same_multiply: got %b want 1", multiply); end
    endtask

    // Pin low in cycle 14 -> synced low in cycle 16 at settle count 10; full 16 needed again.
    task automatic test_lock_glitch;
        int lo, dn, at, rh; logic r0;
        run_req(1'b0, 0, 14, 15, 40, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (lo != 34) begin n_errs++; $display("FAIL glitch_gated: got %0d want 34", lo); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL glitch_done_cnt: got %0d want 1", dn); end
        n_checks++; if (at != 35) begin n_errs++; $display("FAIL glitch_done_at: got %0d want 35", at); end
        n_checks++; if (multiply !== 1'b0) begin n_errs++; $display("FAIL glitch_multiply: got %b want 0", multiply); end
    endtask

    // Lock pin low until cycle 20 keeps RELOCK busy while req_valid is held high.
    task automatic test_back_to_back;
        int lo, dn, at, rh; logic r0;
        run_req(1'b1, 20, 0, 20, 46, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (rh != 0) begin n_errs++; $display("FAIL b2b_ready_busy: got %0d high cycles want 0", rh); end
        n_checks++; if (lo != 39) begin n_errs++; $display("FAIL b2b_gated: got %0d want 39", lo); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL b2b_done_cnt: got %0d want 1", dn); end
        n_checks++; if (multiply !== 1'b1) begin n_errs++; $display("FAIL b2b_multiply: got %b want 1", multiply); end
    endtask

    task automatic test_reset_in_drain;
        int dn, lo;
        @(posedge clk); #1;
        req_valid = 1'b1; req_mult = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (clk_en !== 1'b0) begin n_errs++; $display("FAIL drain_clk_en: got %b want 0", clk_en); end
        n_checks++; if (multiply !== 1'b1) begin n_errs++; $display("FAIL drain_multiply: got %b want 1", multiply); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (clk_en !== 1'b1) begin n_errs++; $display("FAIL abort_clk_en: got %b want 1", clk_en); end
        n_checks++; if (multiply !== 1'b0) begin n_errs++; $display("FAIL abort_multiply: got %b want 0", multiply); end
        n_checks++; if (req_ready !== 1'b1) begin n_errs++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        dn = 0; lo = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (!clk_en) lo++;
        end
        n_checks++; if (dn != 0) begin n_errs++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
        n_checks++; if (lo != 0) begin n_errs++; $display("FAIL abort_gated: got %0d want 0", lo); end
    endtask

    task automatic test_timeout;
        int lo, dn, at, rh; logic r0;
`ifdef CLK_MULT_CTRL_TIMEOUT_EN
        // RELOCK from cycle 5, watchdog expires after 1024 cycles -> RESUME in 1029.
        run_req(1'b1, 0, 0, 1035, 1035, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (lo != 1029) begin n_errs++; $display("FAIL tmo_gated: got %0d want 1029", lo); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL tmo_done_cnt: got %0d want 1", dn); end
        n_checks++; if (at != 1030) begin n_errs++; $display("FAIL tmo_done_at: got %0d want 1030", at); end
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL tmo_err: got %b want 1", err); end
        n_checks++; if (multiply !== 1'b0) begin n_errs++; $display("FAIL tmo_multiply: got %b want 0", multiply); end
        n_checks++; if (clk_en !== 1'b1) begin n_errs++; $display("FAIL tmo_clk_en: got %b want 1", clk_en); end
        run_req(1'b0, 0, 0, 0, 4, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL tmo_err_clear: got %b want 0", err); end
        n_checks++; if (dn != 1) begin n_errs++; $display("FAIL tmo_same_done: got %0d want 1", dn); end
`else
        // Without the watchdog the controller waits in RELOCK indefinitely.
        run_req(1'b1, 0, 0, 1100, 1100, lo, dn, at, rh, r0);
        @(negedge clk);
        n_checks++; if (lo != 1099) begin n_errs++; $display("FAIL stall_gated: got %0d want 1099", lo); end
        n_checks++; if (dn != 0) begin n_errs++; $display("FAIL stall_done_cnt: got %0d want 0", dn); end
        n_checks++; if (clk_en !== 1'b0) begin n_errs++; $display("FAIL stall_clk_en: got %b want 0", clk_en); end
        n_checks++; if (multiply !== 1'b1) begin n_errs++; $display("FAIL stall_multiply: got %b want 1", multiply); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL stall_err: got %b want 0", err); end
        n_checks++; if (req_ready !== 1'b0) begin n_errs++; $display("FAIL stall_ready: got %b want 0", req_ready); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (clk_en !== 1'b1) begin n_errs++; $display("FAIL stall_reset_clk_en: got %b want 1", clk_en); end
`endif
    endtask

    initial begin
        test_reset;
        test_switch_up;
        test_same_mode;
        test_lock_glitch;
        test_back_to_back;
        test_reset_in_drain;
        test_timeout;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
